// File: rtl/float_copro_pkg.sv
// Shared types and helpers for the queued float coprocessor: opcodes, FSM states,
// request layout and IEEE-754 single packing.
package float_copro_pkg;

  localparam logic [10:0] OP_ADD = 11'd0;
  localparam logic [10:0] OP_SUB = 11'd1;
  localparam logic [10:0] OP_MUL = 11'd2;
  localparam logic [10:0] OP_DIV = 11'd3;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} copro_state_t;

  typedef struct packed {
    logic [10:0] opcode;
    logic [31:0] op0;
    logic [31:0] op1;
  } copro_req_t;

  localparam int REQ_W = $bits(copro_req_t);

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_legal(logic [10:0] opcode);
    return opcode <= OP_DIV;
  endfunction

  // Biased exponent may be out of range: underflow flushes to zero, overflow saturates to inf.
  function automatic logic [31:0] pack_fp(logic sign, logic signed [9:0] e_val, logic [22:0] frac);
    if (e_val <= 10'sd0) return {sign, 31'b0};
    if (e_val >= 10'sd255) return {sign, 8'hFF, 23'b0};
    return {sign, e_val[7:0], frac};
  endfunction

endpackage

// File: rtl/copro_req_fifo.sv
// Request FIFO for the float coprocessor: DEPTH entries of packed requests, sync reset.
module copro_req_fifo
  import float_copro_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [REQ_W-1:0] din,
  output logic [REQ_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [REQ_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CNTW'(1);
      else if (!do_push && do_pop) count <= count - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/float_copro_dp.sv
// Combinational single-precision add/sub/mul/div. Subnormals flush to zero,
// results truncate; illegal opcodes yield zero.
module float_copro_dp
  import float_copro_pkg::*;
(
  input  logic [10:0] opcode,
  input  logic [31:0] op0,
  input  logic [31:0] op1,
  output logic [31:0] result
);

  logic        sa, sb, sb_eff, swap, big_s, sml_s;
  logic [7:0]  ea, eb, big_e, sml_e, diff;
  logic [23:0] ma, mb, big_m, sml_m;
  logic [26:0] aligned;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [22:0] frac_n;
  logic [24:0] prod_hi, quo;
  logic signed [9:0] mul_e, div_e;
  logic [31:0] add_res, mul_res, div_res;

  assign sa = op0[31];
  assign sb = op1[31];
  assign ea = op0[30:23];
  assign eb = op1[30:23];
  assign ma = (ea == 8'd0) ? 24'd0 : {1'b1, op0[22:0]};
  assign mb = (eb == 8'd0) ? 24'd0 : {1'b1, op1[22:0]};

  // Add/sub: order by magnitude so the larger operand fixes sign and exponent.
  always_comb begin
    sb_eff  = sb ^ (opcode == OP_SUB);
    swap    = {ea, ma} < {eb, mb};
    big_s   = swap ? sb_eff : sa;
    sml_s   = swap ? sa : sb_eff;
    big_e   = swap ? eb : ea;
    sml_e   = swap ? ea : eb;
    big_m   = swap ? mb : ma;
    sml_m   = swap ? ma : mb;
    diff    = big_e - sml_e;
    aligned = (diff > 8'd26) ? 27'd0 : ({sml_m, 3'b0} >> diff);
    if (big_s == sml_s) sum = {1'b0, big_m, 3'b0} + {1'b0, aligned};
    else                sum = {1'b0, big_m, 3'b0} - {1'b0, aligned};
    lz = '0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    frac_n = 23'((sum[26:0] << lz) >> 3);
    if (sum == '0)    add_res = 32'h0;
    else if (sum[27]) add_res = pack_fp(big_s, {2'b0, big_e} + 10'd1, sum[26:4]);
    else              add_res = pack_fp(big_s, {2'b0, big_e} - {5'b0, lz}, frac_n);
  end

  always_comb begin
    prod_hi = 25'(({24'b0, ma} * {24'b0, mb}) >> 23);
    mul_e   = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127;
    if (ma == '0 || mb == '0) mul_res = {sa ^ sb, 31'b0};
    else if (prod_hi[24])     mul_res = pack_fp(sa ^ sb, mul_e + 10'sd1, prod_hi[23:1]);
    else                      mul_res = pack_fp(sa ^ sb, mul_e, prod_hi[22:0]);
  end

  always_comb begin
    quo   = (mb == '0) ? 25'd0 : 25'(({ma, 24'b0}) / {24'b0, mb});
    div_e = $signed({2'b0, ea}) - $signed({2'b0, eb}) + 10'sd127;
    if (mb == '0)       div_res = {sa ^ sb, 8'hFF, 23'b0};
    else if (ma == '0)  div_res = {sa ^ sb, 31'b0};
    else if (quo[24])   div_res = pack_fp(sa ^ sb, div_e, quo[23:1]);
    else                div_res = pack_fp(sa ^ sb, div_e - 10'sd1, quo[22:0]);
  end

  always_comb begin
    case (opcode)
      OP_ADD, OP_SUB: result = add_res;
      OP_MUL:         result = mul_res;
      OP_DIV:         result = div_res;
      default:        result = 32'h0;
    endcase
  end

endmodule

// File: rtl/float_copro_queued.sv
// Queued float coprocessor controller: buffers requests, runs them in order with
// per-opcode latency, and holds each result until the host accepts it.
module float_copro_queued
  import float_copro_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int T_ADD = 2,
  parameter int T_SUB = 2,
  parameter int T_MUL = 2,
  parameter int T_DIV = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        copro_valid,
  output logic        copro_ready,
  input  logic [10:0] copro_opcode,
  input  logic [31:0] copro_op0,
  input  logic [31:0] copro_op1,
  output logic        copro_complete,
  output logic [31:0] copro_result,
  output logic        copro_error,
  input  logic        copro_accept,
  output logic        copro_busy
);

  localparam int T_MAX = max_int(max_int(T_ADD, T_SUB), max_int(T_MUL, T_DIV));
  localparam int CW    = $clog2(T_MAX + 1);

  copro_state_t     state;
  copro_req_t       op_reg;
  copro_req_t       head;
  logic [CW-1:0]    cnt;
  logic [REQ_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty, pop;
  logic [31:0]      dp_result;

  function automatic logic [CW-1:0] lat_of(logic [10:0] opcode);
    case (opcode)
      OP_ADD:  return CW'(T_ADD);
      OP_SUB:  return CW'(T_SUB);
      OP_MUL:  return CW'(T_MUL);
      OP_DIV:  return CW'(T_DIV);
      default: return CW'(1);
    endcase
  endfunction

  assign copro_ready = !fifo_full;
  assign copro_busy  = (state != IDLE) || !fifo_empty;
  assign head        = copro_req_t'(fifo_dout);
  // Pop straight from DONE on accept so queued work issues without a bubble.
  assign pop = !fifo_empty && ((state == IDLE) || (state == DONE && copro_accept));

  copro_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (copro_valid && copro_ready),
    .pop   (pop),
    .din   ({copro_opcode, copro_op0, copro_op1}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  float_copro_dp u_dp (
    .opcode (op_reg.opcode),
    .op0    (op_reg.op0),
    .op1    (op_reg.op1),
    .result (dp_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op_reg         <= '0;
      cnt            <= '0;
      copro_complete <= 1'b0;
      copro_result   <= 32'h0;
      copro_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            op_reg <= head;
            cnt    <= lat_of(head.opcode);
            state  <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            copro_result   <= dp_result;
            copro_complete <= 1'b1;
            copro_error    <= !is_legal(op_reg.opcode);
            state          <= DONE;
          end
        end
        DONE: begin
          if (copro_accept) begin
            copro_complete <= 1'b0;
            copro_error    <= 1'b0;
            if (pop) begin
              op_reg <= head;
              cnt    <= lat_of(head.opcode);
              state  <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_copro_queued.sv
// Bench for float_copro_queued: directed scenarios plus random traffic, checked every
// cycle against a transaction-level timing/arithmetic model.
module tb_float_copro_queued;
  import float_copro_pkg::*;

  localparam int DEPTH = 4;
  localparam int T_ADD = 2;
  localparam int T_SUB = 2;
  localparam int T_MUL = 2;
  localparam int T_DIV = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [10:0] opcode = '0;
  logic [31:0] op0 = '0;
  logic [31:0] op1 = '0;
  logic        complete;
  logic [31:0] result;
  logic        error;
  logic        accept = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  float_copro_queued #(
    .DEPTH(DEPTH), .T_ADD(T_ADD), .T_SUB(T_SUB), .T_MUL(T_MUL), .T_DIV(T_DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .copro_valid    (valid),
    .copro_ready    (ready),
    .copro_opcode   (opcode),
    .copro_op0      (op0),
    .copro_op1      (op1),
    .copro_complete (complete),
    .copro_result   (result),
    .copro_error    (error),
    .copro_accept   (accept),
    .copro_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          push_edge;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   prev_acc = -1000;
  bit   live = 0;

  function automatic real s2r(logic [31:0] s);
    logic [63:0] d;
    if (s[30:23] == 8'd0) return 0.0;
    d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'h0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic exp_t make_exp(logic [10:0] opc, logic [31:0] a, logic [31:0] b, int e);
    exp_t x;
    x.push_edge = e;
    x.err = 1'b0;
    case (opc)
      11'd0:   begin x.res = r2s(s2r(a) + s2r(b)); x.lat = T_ADD; end
      11'd1:   begin x.res = r2s(s2r(a) - s2r(b)); x.lat = T_SUB; end
      11'd2:   begin x.res = r2s(s2r(a) * s2r(b)); x.lat = T_MUL; end
      11'd3:   begin x.res = r2s(s2r(a) / s2r(b)); x.lat = T_DIV; end
      default: begin x.res = 32'h0; x.err = 1'b1; x.lat = 1; end
    endcase
    return x;
  endfunction

  // Head starts when it has been queued for an edge and its predecessor has been accepted.
  function automatic int head_start();
    return (prev_acc > q[0].push_edge + 1) ? prev_acc : q[0].push_edge + 1;
  endfunction

  function automatic bit m_complete(int n);
    if (q.size() == 0) return 0;
    return n >= head_start() + q[0].lat;
  endfunction

  function automatic bit m_ready(int n);
    int in_fifo;
    in_fifo = q.size();
    if (q.size() > 0 && head_start() <= n) in_fifo--;
    return in_fifo < DEPTH;
  endfunction

  always @(posedge clk) begin
    bit c_pre, r_pre;
    c_pre = m_complete(cyc);
    r_pre = m_ready(cyc);
    cyc++;
    if (reset) begin
      q.delete();
      prev_acc = -1000;
      live = 1;
    end else if (live) begin
      if (accept && c_pre) begin
        void'(q.pop_front());
        prev_acc = cyc;
      end
      if (valid && r_pre) q.push_back(make_exp(opcode, op0, op1, cyc));
    end
  end

  always @(negedge clk) begin
    bit c;
    if (live) begin
      c = m_complete(cyc);
      chk("cmp_complete", complete, c);
      chk("cmp_ready", ready, m_ready(cyc));
      chk("cmp_busy", busy, q.size() > 0);
      chk("cmp_error", error, c ? q[0].err : 1'b0);
      if (c) chk("cmp_result", result, q[0].res);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [10:0] opc, logic [31:0] a, logic [31:0] b);
    int guard;
    guard = 0;
    valid = 1'b1; opcode = opc; op0 = a; op1 = b;
    while (!ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 32'd1, 32'd0);
    tick();
    valid = 1'b0;
  endtask

  task automatic do_accept();
    accept = 1'b1;
    tick();
    accept = 1'b0;
  endtask

  function automatic logic [31:0] rnd_int_f();
    int v;
    v = int'($urandom_range(1, 200));
    if ($urandom_range(0, 1) == 1) v = -v;
    return r2s(real'(v));
  endfunction

  function automatic logic [31:0] rnd_pow2_f();
    int v;
    v = 1 << $urandom_range(0, 4);
    if ($urandom_range(0, 1) == 1) v = -v;
    return r2s(real'(v));
  endfunction

  initial begin
    int n;
    int seen;
    bit pend;
    logic [10:0] ropc;

    // Pin the model arithmetic with hand-computed values.
    chk("model_add", make_exp(OP_ADD, 32'h3FC00000, 32'h40100000, 0).res, 32'h40700000);
    chk("model_div", make_exp(OP_DIV, 32'h3F800000, 32'h40800000, 0).res, 32'h3E800000);
    chk("model_mul", make_exp(OP_MUL, 32'h40000000, 32'h40400000, 0).res, 32'h40C00000);
    chk("model_sub", make_exp(OP_SUB, 32'h40A00000, 32'h40E00000, 0).res, 32'hC0000000);

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_complete", complete, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_error", error, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);

    // Add: 1.5 + 2.25
    send(OP_ADD, 32'h3FC00000, 32'h40100000);
    tick(); tick();
    chk("add_early", complete, 1'b0);
    tick();
    chk("add_lat", complete, 1'b1);
    chk("add_result", result, 32'h40700000);
    repeat (4) tick();
    chk("add_hold_c", complete, 1'b1);
    chk("add_hold_r", result, 32'h40700000);
    do_accept();
    chk("add_acc_c", complete, 1'b0);
    chk("add_acc_busy", busy, 1'b0);

    // Div: 1.0 / 4.0
    send(OP_DIV, 32'h3F800000, 32'h40800000);
    repeat (12) tick();
    chk("div_early", complete, 1'b0);
    tick();
    chk("div_lat", complete, 1'b1);
    chk("div_result", result, 32'h3E800000);
    do_accept();

    // Six back-to-back muls with accept low
    valid = 1'b1; opcode = OP_MUL; op0 = 32'h40000000; op1 = 32'h40400000;
    repeat (5) tick();
    chk("mul_full_ready", ready, 1'b0);
    chk("mul_full_busy", busy, 1'b1);
    pend = 1;
    for (int r = 0; r < 6; r++) begin
      n = 0;
      if (pend && ready) begin
        tick();
        valid = 1'b0;
        pend = 0;
        n = 1;
      end
      while (!complete && n < 60) begin
        tick();
        n++;
      end
      if (r > 0) chk("mul_gap", n, 2);
      chk("mul_result", result, 32'h40C00000);
      chk("mul_error", error, 1'b0);
      do_accept();
    end
    valid = 1'b0;
    tick();
    chk("mul_drain_busy", busy, 1'b0);

    // Illegal opcode then a legal add
    send(11'd7, 32'h12345678, 32'h9ABCDEF0);
    tick();
    chk("ill_early", complete, 1'b0);
    tick();
    chk("ill_lat", complete, 1'b1);
    chk("ill_error", error, 1'b1);
    chk("ill_result", result, 32'h0);
    do_accept();
    chk("ill_acc_err", error, 1'b0);
    send(OP_ADD, 32'h3FC00000, 32'h40100000);
    n = 0;
    while (!complete && n < 60) begin
      tick();
      n++;
    end
    chk("post_ill_error", error, 1'b0);
    chk("post_ill_result", result, 32'h40700000);
    do_accept();

    // Spurious accepts
    do_accept();
    chk("spur_idle_busy", busy, 1'b0);
    chk("spur_idle_ready", ready, 1'b1);
    send(OP_ADD, 32'h3FC00000, 32'h40100000);
    tick();
    do_accept();
    chk("spur_exec_c", complete, 1'b0);
    tick();
    chk("spur_exec_lat", complete, 1'b1);
    chk("spur_exec_r", result, 32'h40700000);
    do_accept();

    // Reset mid-div with two queued
    send(OP_DIV, 32'h3F800000, 32'h40800000);
    send(OP_DIV, 32'h40000000, 32'h40000000);
    send(OP_DIV, 32'h40400000, 32'h3F800000);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_complete", complete, 1'b0);
    chk("mrst_ready", ready, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    seen = 0;
    repeat (20) begin
      tick();
      if (complete) seen++;
    end
    chk("mrst_no_stale", seen, 0);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      if (!valid || ready) begin
        valid = ($urandom_range(0, 2) != 0);
        ropc = 11'($urandom_range(0, 9));
        if (ropc > 11'd8) ropc = 11'($urandom_range(4, 2047));
        else ropc = ropc % 11'd4;
        opcode = ropc;
        op0 = (ropc > 11'd3) ? 32'($urandom) : rnd_int_f();
        op1 = (ropc == OP_DIV) ? rnd_pow2_f() : (ropc > 11'd3) ? 32'($urandom) : rnd_int_f();
      end
      accept = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    valid = 1'b0;
    reset = 1'b0;
    accept = 1'b1;
    repeat (120) tick();
    accept = 1'b0;
    chk("final_busy", busy, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
